// File: rtl/tt_sweep_ctrl.sv
// tt_sweep_ctrl: steps a 4-bit address through all 16 input combinations of a
// function block, waits a settle time at each address, samples f_in, and
// compares it against an expected truth table with per-address don't-cares.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for start; result/err_cnt/pass hold the last sweep
// SETTLE | address A driven, settle down-counter running
// SAMPLE | one cycle; f_in captured into result[A] at the closing edge
module tt_sweep_ctrl #(
    parameter int SETTLE_CYC = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic [15:0] exp_val,
    input  logic [15:0] care_mask,
    output logic [3:0]  A,
    input  logic        f_in,
    output logic        busy,
    output logic        done,
    output logic        aborted,
    output logic [15:0] result,
    output logic [4:0]  err_cnt,
    output logic        pass
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2
    } state_t;

    localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYC);
    localparam bit         NO_SETTLE = (SETTLE_CYC == 0);

    state_t      state_q;
    state_t      state_d;
    logic [3:0]  cnt_q;
    logic [3:0]  a_q;
    logic [15:0] exp_q;
    logic [15:0] care_q;
    logic [15:0] result_q;
    logic [4:0]  err_q;
    logic        pass_q;
    logic        done_q;
    logic        aborted_q;

    logic        go;
    logic        kill;
    logic        smp;
    logic        miss;
    logic [4:0]  err_next;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; abort has priority over the final sample
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = NO_SETTLE ? SAMPLE : SETTLE;
                end
            end
            SETTLE: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (cnt_q <= 4'd1) begin
                    state_d = SAMPLE;
                end
            end
            SAMPLE: begin
                if (abort || (a_q == 4'd15)) begin
                    state_d = IDLE;
                end else begin
                    state_d = NO_SETTLE ? SAMPLE : SETTLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control decode for the datapath
    always_comb begin
        go       = (state_q == IDLE) && start;
        kill     = (state_q != IDLE) && abort;
        smp      = (state_q == SAMPLE) && !abort;
        miss     = care_q[a_q] && (f_in != exp_q[a_q]);
        err_next = err_q + {4'd0, miss};
    end

    // Datapath: address, settle timer, latched masks, results and pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            a_q       <= '0;
            exp_q     <= '0;
            care_q    <= '0;
            result_q  <= '0;
            err_q     <= '0;
            pass_q    <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            if (go) begin
                exp_q    <= exp_val;
                care_q   <= care_mask;
                result_q <= '0;
                err_q    <= '0;
                pass_q   <= 1'b0;
                a_q      <= '0;
                cnt_q    <= SETTLE_LD;
            end else if (kill) begin
                aborted_q <= 1'b1;
                a_q       <= '0;
                cnt_q     <= '0;
                pass_q    <= 1'b0;
            end else if (smp) begin
                result_q[a_q] <= f_in;
                err_q         <= err_next;
                if (a_q == 4'd15) begin
                    done_q <= 1'b1;
                    a_q    <= '0;
                    cnt_q  <= '0;
                    pass_q <= (err_next == 5'd0);
                end else begin
                    a_q   <= a_q + 4'd1;
                    cnt_q <= SETTLE_LD;
                end
            end else if ((state_q == SETTLE) && (cnt_q != 4'd0)) begin
                cnt_q <= cnt_q - 4'd1;
            end
        end
    end

    assign A       = a_q;
    assign busy    = (state_q != IDLE);
    assign done    = done_q;
    assign aborted = aborted_q;
    assign result  = result_q;
    assign err_cnt = err_q;
    assign pass    = pass_q;

endmodule

// File: tb/tb_tt_sweep_ctrl.sv
// Bench for tt_sweep_ctrl: one instance with settle time 2 (index 0) and one
// with settle time 0 (index 1), each driving a truth-table "function block".
module tb_tt_sweep_ctrl;

    logic        clk;
    logic        rst;
    logic        start_v   [2];
    logic        abort_v   [2];
    logic        f_v       [2];
    logic        busy_v    [2];
    logic        done_v    [2];
    logic        aborted_v [2];
    logic        pass_v    [2];
    logic [15:0] exp_v     [2];
    logic [15:0] care_v    [2];
    logic [15:0] result_v  [2];
    logic [15:0] fvec      [2];
    logic [3:0]  a_v       [2];
    logic [4:0]  err_v     [2];

    int checks   = 0;
    int failures = 0;

    assign f_v[0] = fvec[0][a_v[0]];
    assign f_v[1] = fvec[1][a_v[1]];

    tt_sweep_ctrl #(.SETTLE_CYC(2)) dut (
        .clk(clk), .rst(rst), .start(start_v[0]), .abort(abort_v[0]),
        .exp_val(exp_v[0]), .care_mask(care_v[0]), .A(a_v[0]), .f_in(f_v[0]),
        .busy(busy_v[0]), .done(done_v[0]), .aborted(aborted_v[0]),
        .result(result_v[0]), .err_cnt(err_v[0]), .pass(pass_v[0])
    );

    tt_sweep_ctrl #(.SETTLE_CYC(0)) dut0 (
        .clk(clk), .rst(rst), .start(start_v[1]), .abort(abort_v[1]),
        .exp_val(exp_v[1]), .care_mask(care_v[1]), .A(a_v[1]), .f_in(f_v[1]),
        .busy(busy_v[1]), .done(done_v[1]), .aborted(aborted_v[1]),
        .result(result_v[1]), .err_cnt(err_v[1]), .pass(pass_v[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #300000;
        $display("FAIL global_timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    function automatic int settle_of(input int d);
        return (d == 0) ? 2 : 0;
    endfunction

    // Drives one sweep and records what the DUT did; edge 0 is acceptance.
    // Expected address after edge k is k/(S+1) until the sweep ends, then 0.
    task automatic run_sweep(input int d, input logic [15:0] fv, input logic [15:0] ex,
                             input logic [15:0] cr, input int abort_at, input int restart_at,
                             output int done_k, output int abort_k, output int a_bad);
        int s;
        int ea;
        s = settle_of(d);
        done_k = -1;
        abort_k = -1;
        a_bad = 0;
        @(negedge clk);
        fvec[d]    = fv;
        exp_v[d]   = ex;
        care_v[d]  = cr;
        start_v[d] = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(posedge clk);
            #1;
            start_v[d] = 1'b0;
            abort_v[d] = 1'b0;
            ea = (k < 16 * (s + 1)) ? k / (s + 1) : 0;
            if (abort_at >= 0 && k >= abort_at) ea = 0;
            if (a_v[d] !== 4'(ea)) a_bad++;
            if (done_v[d] === 1'b1) done_k = k;
            if (aborted_v[d] === 1'b1) abort_k = k;
            if (done_k >= 0 || abort_k >= 0) break;
            if (k + 1 == abort_at) abort_v[d] = 1'b1;
            if (k + 1 == restart_at) begin
                start_v[d] = 1'b1;
                exp_v[d]   = ~ex;
                care_v[d]  = 16'hFFFF;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            start_v[d] = 1'b0; abort_v[d] = 1'b0;
            exp_v[d] = 16'h0; care_v[d] = 16'h0; fvec[d] = 16'hFFFF;
        end
        #2;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if ({a_v[d], busy_v[d], done_v[d], aborted_v[d], result_v[d], err_v[d], pass_v[d]} !== 29'd0) begin
                failures++;
                $display("FAIL reset_outputs dut=%0d got A=%h busy=%b done=%b ab=%b res=%h err=%0d pass=%b required all zero",
                         d, a_v[d], busy_v[d], done_v[d], aborted_v[d], result_v[d], err_v[d], pass_v[d]);
            end
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_sweep(input int d, input string name, input logic [15:0] fv,
                              input logic [15:0] ex, input logic [15:0] cr);
        int dk, ak, ab, s, ee;
        s = settle_of(d);
        ee = $countones((fv ^ ex) & cr);
        run_sweep(d, fv, ex, cr, -1, -1, dk, ak, ab);
        checks++;
        if (dk != 16 * (s + 1)) begin
            failures++; $display("FAIL %s done_edge got=%0d required=%0d", name, dk, 16 * (s + 1));
        end
        checks++;
        if (ab != 0 || ak != -1) begin
            failures++; $display("FAIL %s addr_trace bad_cycles=%0d aborted_edge=%0d required 0 and -1", name, ab, ak);
        end
        checks++;
        if (result_v[d] !== fv) begin
            failures++; $display("FAIL %s result got=%h required=%h", name, result_v[d], fv);
        end
        checks++;
        if (err_v[d] !== 5'(ee)) begin
            failures++; $display("FAIL %s err_cnt got=%0d required=%0d", name, err_v[d], ee);
        end
        checks++;
        if (pass_v[d] !== (ee == 0) || busy_v[d] !== 1'b0) begin
            failures++; $display("FAIL %s pass/busy got=%b/%b required=%b/0", name, pass_v[d], busy_v[d], ee == 0);
        end
        @(posedge clk);
        #1;
        checks++;
        if (done_v[d] !== 1'b0) begin
            failures++; $display("FAIL %s done_width got=%b required=0", name, done_v[d]);
        end
    endtask

    task automatic test_abort(input int d, input string name, input logic [15:0] fv,
                              input logic [15:0] ex, input logic [15:0] cr, input int at);
        int dk, ak, ab, s, n, ee;
        logic [15:0] m;
        s = settle_of(d);
        n = (at - 1) / (s + 1);
        m = 16'((32'd1 << n) - 32'd1);
        ee = $countones((fv ^ ex) & cr & m);
        run_sweep(d, fv, ex, cr, at, -1, dk, ak, ab);
        checks++;
        if (ak != at || dk != -1) begin
            failures++; $display("FAIL %s abort_edge got=%0d done_edge=%0d required=%0d and -1", name, ak, dk, at);
        end
        checks++;
        if (ab != 0) begin
            failures++; $display("FAIL %s addr_trace bad_cycles=%0d required=0", name, ab);
        end
        checks++;
        if (result_v[d] !== (fv & m) || err_v[d] !== 5'(ee)) begin
            failures++; $display("FAIL %s partial got res=%h err=%0d required res=%h err=%0d",
                                 name, result_v[d], err_v[d], fv & m, ee);
        end
        checks++;
        if (pass_v[d] !== 1'b0 || busy_v[d] !== 1'b0 || done_v[d] !== 1'b0) begin
            failures++; $display("FAIL %s pass/busy/done got=%b/%b/%b required=0/0/0", name, pass_v[d], busy_v[d], done_v[d]);
        end
        @(posedge clk);
        #1;
        checks++;
        if (aborted_v[d] !== 1'b0 || done_v[d] !== 1'b0) begin
            failures++; $display("FAIL %s pulse_width got ab=%b done=%b required 0/0", name, aborted_v[d], done_v[d]);
        end
    endtask

    task automatic test_hold(input int d, input logic [15:0] res, input int ee);
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            exp_v[d]   = 16'($urandom());
            care_v[d]  = 16'($urandom());
            fvec[d]    = 16'($urandom());
            abort_v[d] = 1'b1;
            @(posedge clk);
            #1;
            checks++;
            if (result_v[d] !== res || err_v[d] !== 5'(ee) || pass_v[d] !== (ee == 0)
                || busy_v[d] !== 1'b0 || aborted_v[d] !== 1'b0) begin
                failures++;
                $display("FAIL idle_hold cycle=%0d got res=%h err=%0d pass=%b busy=%b ab=%b required res=%h err=%0d pass=%b",
                         k, result_v[d], err_v[d], pass_v[d], busy_v[d], aborted_v[d], res, ee, ee == 0);
            end
        end
        abort_v[d] = 1'b0;
    endtask

    task automatic test_back_to_back_start();
        int dk, ak, ab;
        logic [15:0] fv, ex, cr;
        fv = 16'h3A5C; ex = 16'h3A5D; cr = 16'hFFFE;
        run_sweep(1, fv, ex, cr, -1, 7, dk, ak, ab);
        checks++;
        if (dk != 16 || ab != 0) begin
            failures++; $display("FAIL restart_ignored done_edge got=%0d bad_addr=%0d required 16 and 0", dk, ab);
        end
        checks++;
        if (result_v[1] !== fv || err_v[1] !== 5'd0 || pass_v[1] !== 1'b1) begin
            failures++; $display("FAIL restart_masks got res=%h err=%0d pass=%b required res=%h err=0 pass=1",
                                 result_v[1], err_v[1], pass_v[1], fv);
        end
    endtask

    task automatic test_start_abort_idle();
        bit seen;
        seen = 1'b0;
        @(negedge clk);
        fvec[1] = 16'h0F0F; exp_v[1] = 16'h0F0F; care_v[1] = 16'hFFFF;
        start_v[1] = 1'b1; abort_v[1] = 1'b1;
        @(posedge clk);
        #1;
        start_v[1] = 1'b0; abort_v[1] = 1'b0;
        checks++;
        if (busy_v[1] !== 1'b1 || aborted_v[1] !== 1'b0) begin
            failures++; $display("FAIL start_abort_idle got busy=%b ab=%b required 1/0", busy_v[1], aborted_v[1]);
        end
        for (int k = 0; k < 40 && !seen; k++) begin
            @(posedge clk);
            #1;
            if (done_v[1] === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen || pass_v[1] !== 1'b1) begin
            failures++; $display("FAIL start_abort_done got done_seen=%b pass=%b required 1/1", seen, pass_v[1]);
        end
    endtask

    task automatic test_async_reset();
        bit pulse;
        pulse = 1'b0;
        @(negedge clk);
        fvec[0] = 16'hFFFF; exp_v[0] = 16'h0000; care_v[0] = 16'hFFFF; start_v[0] = 1'b1;
        @(posedge clk);
        #1;
        start_v[0] = 1'b0;
        repeat (27) @(posedge clk);
        #1;
        checks++;
        if (a_v[0] !== 4'd9 || busy_v[0] !== 1'b1) begin
            failures++; $display("FAIL async_pre got A=%0d busy=%b required 9/1", a_v[0], busy_v[0]);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({a_v[0], busy_v[0], done_v[0], aborted_v[0], result_v[0], err_v[0], pass_v[0]} !== 29'd0) begin
            failures++;
            $display("FAIL async_reset got A=%h busy=%b res=%h err=%0d pass=%b required all zero",
                     a_v[0], busy_v[0], result_v[0], err_v[0], pass_v[0]);
        end
        #1 rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            if (done_v[0] !== 1'b0 || aborted_v[0] !== 1'b0 || busy_v[0] !== 1'b0 || a_v[0] !== 4'd0) pulse = 1'b1;
        end
        checks++;
        if (pulse) begin
            failures++; $display("FAIL async_after got activity after reset required idle and no pulses");
        end
        test_sweep(0, "async_clean", 16'h6D21, 16'h6D20, 16'hFFFF);
    endtask

    task automatic test_random();
        logic [15:0] fv, ex, cr;
        int d, s;
        for (int i = 0; i < 10; i++) begin
            d  = i % 2;
            s  = settle_of(d);
            fv = 16'($urandom());
            cr = 16'($urandom());
            ex = (i % 3 == 0) ? (fv ^ (16'($urandom()) & ~cr)) : 16'($urandom());
            if (i % 4 == 3) test_abort(d, "rand_abort", fv, ex, cr, int'($urandom_range(1, 16 * (s + 1))));
            else            test_sweep(d, "rand_sweep", fv, ex, cr);
        end
    endtask

    initial begin
        test_reset();
        test_sweep(0, "v1_exact", 16'hC090, 16'hC090, 16'hFFFF);
        test_hold(0, 16'hC090, 0);
        test_sweep(0, "v2_dontcare", 16'hC4B0, 16'hC090, 16'hF3DF);
        test_sweep(0, "v3_care", 16'hC4B0, 16'hC090, 16'hFFFF);
        test_abort(0, "v4_abort_a7", 16'hC090, 16'h0000, 16'hFFFF, 22);
        test_abort(0, "abort_last", 16'hFFFF, 16'h0000, 16'hFFFF, 48);
        test_sweep(0, "all_wrong", 16'hFFFF, 16'h0000, 16'hFFFF);
        test_back_to_back_start();
        test_start_abort_idle();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tt_sweep_ctrl.md
TT_SWEEP_CTRL -- requirements
Module: tt_sweep_ctrl

Interface
REQ-001 Parameter SETTLE_CYC, default 2, meaning: idle cycles each address is held before f_in is sampled; legal range 0..15.
REQ-002 clk  input  1  sole clock; all state changes on the rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  request a full sweep; sampled only in IDLE.
REQ-005 abort  input  1  cancel a sweep in progress; sampled only while busy.
REQ-006 exp_val  input  16  expected f for each address; bit i corresponds to A=i.
REQ-007 care_mask  input  16  bit i=1 means address i is checked; 0 means don't-care.
REQ-008 A  output  4  address driven to the 4-input function block under test.
REQ-009 f_in  input  1  function block output for the current A.
REQ-010 busy  output  1  high from start acceptance until done or abort.
REQ-011 done  output  1  one-cycle pulse when a sweep completes normally.
REQ-012 aborted  output  1  one-cycle pulse when a sweep is cancelled.
REQ-013 result  output  16  sampled f values; bit i is the value sampled at A=i.
REQ-014 err_cnt  output  5  number of cared addresses that mismatched, range 0..16.
REQ-015 pass  output  1  high when the last completed sweep had err_cnt=0.

Function
REQ-016 The FSM SHALL have three states: IDLE, SETTLE and SAMPLE; done and aborted are registered pulses, not separate states.
REQ-017 In IDLE with start=1, the block SHALL, at that edge:
  - latch exp_val and care_mask internally;
  - clear result, err_cnt and pass;
  - set A=0 and busy=1;
  - load the settle counter with SETTLE_CYC;
  - enter SETTLE, or enter SAMPLE directly if SETTLE_CYC=0.
REQ-018 In SETTLE, the counter SHALL decrement each cycle, and the FSM SHALL enter SAMPLE on the edge where the counter reaches 0.
REQ-019 In SAMPLE, the block SHALL spend exactly one cycle and, at its closing edge:
  - write f_in into result[A];
  - increment err_cnt if care[A]=1 and f_in differs from exp[A].
REQ-020 After sampling A<15, the block SHALL increment A, reload the counter and return to SETTLE, or stay in SAMPLE if SETTLE_CYC=0.
REQ-021 At the sampling edge for A=15, the block SHALL:
  - pulse done=1 for one cycle;
  - set busy=0 and A=0;
  - set pass=1 if the final err_cnt, including this sample, is 0;
  - return to IDLE.
REQ-022 Each address SHALL occupy SETTLE_CYC+1 cycles, so done is high exactly 16*(SETTLE_CYC+1) cycles after the start-acceptance edge.
REQ-023 result, err_cnt and pass SHALL hold their values in IDLE until the next accepted start.
REQ-024 start while busy SHALL be ignored, with no restart and no effect on the latched masks.
REQ-025 Changes to exp_val or care_mask while busy SHALL have no effect.
REQ-026 abort=1 while busy SHALL, at that edge:
  - pulse aborted=1;
  - set busy=0 and A=0, and return to IDLE;
  - leave result and err_cnt holding partial values;
  - set pass=0;
  - not assert done.
REQ-027 If abort and the final SAMPLE coincide, abort SHALL win: aborted=1, done=0, pass=0.
REQ-028 start and abort in the same IDLE cycle SHALL start a sweep; abort is ignored because the block is not busy.
REQ-029 err_cnt SHALL never wrap; it is 5 bits and the maximum reachable value is 16.

Reset
REQ-030 While rst=1, all of the following SHALL be forced to 0 immediately, independent of clk: A, busy, done, aborted, result, err_cnt, pass, settle counter and latched masks; the FSM SHALL be in IDLE.
REQ-031 rst asserted mid-sweep SHALL produce no done or aborted pulse, and the first edge after release SHALL see IDLE.

Verification
REQ-032 The bench SHALL cover these directed scenarios:
  - V1: SETTLE_CYC=2, f_in modelled as exp=16'hC090, care=16'hFFFF, start at edge 0 -> A steps 0..15, each held 3 cycles; done at edge 48; result=16'hC090, err_cnt=0, pass=1.
  - V2: Same setup, but the model forces f_in=1 at A=5 and A=10, with care=16'hF3DF -> err_cnt=0, pass=1 (both are don't-cares); result[5]=1, result[10]=1.
  - V3: Same as V2 but care=16'hFFFF -> err_cnt=2, pass=0.
  - V4: abort asserted at the edge where A=7 is being settled -> aborted pulses, done never pulses, busy=0, result[15:7]=0, pass=0.
  - V5: SETTLE_CYC=0, plus a second start pulse mid-sweep -> done exactly 16 cycles after acceptance; the second start has no effect.
  - V6: rst pulsed asynchronously between clock edges at A=9 -> all outputs read 0 before the next edge; a subsequent start runs a clean full sweep.
